// File: rtl/deco_hold_secuenciador.sv
// Hold-strobe sequencer for the RTC time/date/timer register bank.
// Requests each register from the bus controller. When data is accepted, it pulls
// the matching active-low hold strobe for one cycle. It runs for a single
// register or sweeps the whole bank, with a per-register timeout.
module deco_hold_secuenciador #(
    parameter int NUM_REGS  = 10,
    parameter int ADDR_W    = 4,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                mode_i,
    input  logic [ADDR_W-1:0]   addr_in_i,
    input  logic                reg_rd_i,
    input  logic                data_valid_i,
    output logic                rd_req_o,
    output logic [ADDR_W-1:0]   addr_out_o,
    output logic [NUM_REGS-1:0] hold_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    // One extra bit so that addr_in - BASE_ADDR can be range-checked without wrapping.
    localparam int               IDX_W    = ADDR_W + 1;
    localparam logic [IDX_W-1:0] BASE_EXT = IDX_W'(BASE_ADDR);
    localparam logic [IDX_W-1:0] NUM_EXT  = IDX_W'(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAPT} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [7:0]            tmo_q, tmo_d;
    logic                  sweep_q, sweep_d;
    logic                  rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]     addr_out_q, addr_out_d;
    logic [NUM_REGS-1:0]   hold_q, hold_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [IDX_W-1:0]      addr_ext;
    logic [IDX_W-1:0]      addr_offset;
    logic                  addr_bad;
    logic [IDX_W-1:0]      index_inc;
    logic [NUM_REGS-1:0]   sel_onehot;

    assign addr_ext    = {1'b0, addr_in_i};
    assign addr_offset = addr_ext - BASE_EXT;
    assign addr_bad    = (addr_ext < BASE_EXT) || (addr_offset >= NUM_EXT);
    assign index_inc   = index_q + IDX_W'(1);

    // Decode of the current index into the strobe that goes low during capture.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
        assign sel_onehot[gi] = (index_q == IDX_W'(gi));
    end

    // State and registered outputs; reset aborts any operation with all holds released.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            tmo_q      <= '0;
            sweep_q    <= 1'b0;
            rd_req_q   <= 1'b0;
            addr_out_q <= ADDR_W'(BASE_ADDR);
            hold_q     <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            tmo_q      <= tmo_d;
            sweep_q    <= sweep_d;
            rd_req_q   <= rd_req_d;
            addr_out_q <= addr_out_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next state plus the values that the outputs take in the next cycle.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        tmo_d      = tmo_q;
        sweep_d    = sweep_q;
        rd_req_d   = 1'b0;
        addr_out_d = addr_out_q;
        hold_d     = '1;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (mode_i) begin
                        sweep_d    = 1'b1;
                        index_d    = '0;
                        tmo_d      = '0;
                        state_d    = S_REQ;
                        rd_req_d   = 1'b1;
                        busy_d     = 1'b1;
                        addr_out_d = ADDR_W'(BASE_EXT);
                    end else if (addr_bad) begin
                        err_d = 1'b1;
                    end else begin
                        sweep_d    = 1'b0;
                        index_d    = addr_offset;
                        tmo_d      = '0;
                        state_d    = S_REQ;
                        rd_req_d   = 1'b1;
                        busy_d     = 1'b1;
                        addr_out_d = addr_in_i;
                    end
                end
            end

            S_REQ: begin
                busy_d = 1'b1;
                if (data_valid_i && !reg_rd_i) begin
                    // Data accepted: strobe the selected register next cycle.
                    state_d = S_CAPT;
                    hold_d  = ~sel_onehot;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    // TIMEOUT cycles spent requesting without an accept.
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    tmo_d   = '0;
                end else begin
                    rd_req_d = 1'b1;
                    tmo_d    = tmo_q + 8'd1;
                end
            end

            S_CAPT: begin
                if (sweep_q && (index_q < LAST_IDX)) begin
                    index_d    = index_inc;
                    state_d    = S_REQ;
                    rd_req_d   = 1'b1;
                    busy_d     = 1'b1;
                    addr_out_d = ADDR_W'(BASE_EXT + index_inc);
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign rd_req_o   = rd_req_q;
    assign addr_out_o = addr_out_q;
    assign hold_o     = hold_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_deco_hold_secuenciador.sv
// Bench for deco_hold_secuenciador. Stimulus pushes the expected strobe, done and
// error events with their cycle numbers. A negedge monitor pops each event and
// compares it against the DUT.
module tb_deco_hold_secuenciador;

    localparam int K_HOLD = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [9:0] hold;
        logic [3:0] addr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [3:0] addr_in;
    logic       reg_rd;
    logic       data_valid;
    logic       rd_req;
    logic [3:0] addr_out;
    logic [9:0] hold;
    logic       busy;
    logic       done;
    logic       err;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    deco_hold_secuenciador #(
        .NUM_REGS (10),
        .ADDR_W   (4),
        .BASE_ADDR(0),
        .TIMEOUT  (255)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .mode_i      (mode),
        .addr_in_i   (addr_in),
        .reg_rd_i    (reg_rd),
        .data_valid_i(data_valid),
        .rd_req_o    (rd_req),
        .addr_out_o  (addr_out),
        .hold_o      (hold),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push(input int kind, input int cy, input logic [9:0] h, input logic [3:0] a);
        exp_t e;
        e.kind = kind;
        e.cyc  = cy;
        e.hold = h;
        e.addr = a;
        exp_q.push_back(e);
    endfunction

    task automatic got_event(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind=%0d hold=%h at cyc %0d, required none", kind, hold, cyc);
        end else begin
            e = exp_q.pop_front();
            $display("txn cyc=%0d kind=%0d hold=%h addr=%0d", cyc, kind, hold, addr_out);
            chk("ev_kind", kind, e.kind);
            chk("ev_cycle", cyc, e.cyc);
            if (kind == K_HOLD) begin
                chk("ev_hold", {22'd0, hold}, {22'd0, e.hold});
                chk("ev_addr", {28'd0, addr_out}, {28'd0, e.addr});
            end
        end
    endtask

    // Monitor: invariants every cycle, plus scoreboard pops on each output event.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("one_hold_low", ($countones(~hold) <= 1) ? 32'd1 : 32'd0, 32'd1);
            chk("done_err_excl", {31'd0, done & err}, 32'd0);
            if (hold != 10'h3FF) got_event(K_HOLD);
            if (done) got_event(K_DONE);
            if (err) got_event(K_ERR);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_hold"}, {22'd0, hold}, 32'h3FF);
        chk({tag, "_rd_req"}, {31'd0, rd_req}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_addr"}, {28'd0, addr_out}, 32'd0);
    endtask

    // Full sweep with data_valid held high: bit i strobes at start+2+2i.
    task automatic run_sweep();
        int c;
        step();
        start = 1'b1; mode = 1'b1; data_valid = 1'b1; reg_rd = 1'b0;
        c = cyc;
        for (int i = 0; i < 10; i++)
            push(K_HOLD, c + 2 + 2 * i, 10'h3FF ^ (10'd1 << i), 4'(i));
        push(K_DONE, c + 21, 10'h3FF, 4'd0);
        step();
        start = 1'b0;
        repeat (24) step();
        data_valid = 1'b0;
        chk("sweep_idle_busy", {31'd0, busy}, 32'd0);
        repeat (2) step();
        drain("sweep_drain");
    endtask

    initial begin
        int c;
        logic [3:0] bad_addrs [2];
        bad_addrs[0] = 4'd12;
        bad_addrs[1] = 4'd10;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; addr_in = 4'd0;
        reg_rd = 1'b0; data_valid = 1'b0;
        repeat (3) step();
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        repeat (20) step();
        check_idle_outputs("idle20");

        // Single read of register 4, data_valid in the 4th request cycle.
        step();
        start = 1'b1; mode = 1'b0; addr_in = 4'd4;
        c = cyc;
        push(K_HOLD, c + 5, 10'h3EF, 4'd4);
        push(K_DONE, c + 6, 10'h3FF, 4'd4);
        for (int t = 1; t <= 6; t++) begin
            step();
            start = 1'b0;
            data_valid = (t == 4);
            chk("single_rd_req", {31'd0, rd_req}, (t <= 4) ? 32'd1 : 32'd0);
            chk("single_busy", {31'd0, busy}, (t <= 5) ? 32'd1 : 32'd0);
            if (t <= 4) chk("single_addr", {28'd0, addr_out}, 32'd4);
        end
        repeat (3) step();
        drain("single_drain");

        run_sweep();

        // Out-of-range addresses: error pulse one cycle later, no request.
        foreach (bad_addrs[k]) begin
            step();
            start = 1'b1; mode = 1'b0; addr_in = bad_addrs[k];
            c = cyc;
            push(K_ERR, c + 1, 10'h3FF, 4'd0);
            for (int t = 1; t <= 4; t++) begin
                step();
                start = 1'b0;
                chk("range_rd_req", {31'd0, rd_req}, 32'd0);
                chk("range_busy", {31'd0, busy}, 32'd0);
                chk("range_hold", {22'd0, hold}, 32'h3FF);
            end
            drain("range_drain");
        end

        // Highest valid register, accepted on the first request cycle.
        step();
        start = 1'b1; mode = 1'b0; addr_in = 4'd9; data_valid = 1'b1;
        c = cyc;
        push(K_HOLD, c + 2, 10'h1FF, 4'd9);
        push(K_DONE, c + 3, 10'h3FF, 4'd9);
        step();
        start = 1'b0;
        repeat (5) step();
        data_valid = 1'b0;
        drain("last_reg_drain");

        // Timeout: data_valid blocked by reg_rd for TIMEOUT request cycles.
        step();
        start = 1'b1; mode = 1'b0; addr_in = 4'd2; reg_rd = 1'b1; data_valid = 1'b1;
        c = cyc;
        push(K_ERR, c + 256, 10'h3FF, 4'd0);
        step();
        start = 1'b0;
        repeat (253) step();
        chk("tmo_addr", {28'd0, addr_out}, 32'd2);
        step();
        chk("tmo_rd_req_last", {31'd0, rd_req}, 32'd1);
        step();
        chk("tmo_rd_req_drop", {31'd0, rd_req}, 32'd0);
        chk("tmo_busy", {31'd0, busy}, 32'd0);
        repeat (3) step();
        reg_rd = 1'b0; data_valid = 1'b0;
        drain("tmo_drain");

        // Reset asserted while requesting index 5 of a sweep.
        step();
        start = 1'b1; mode = 1'b1; data_valid = 1'b1;
        c = cyc;
        for (int i = 0; i < 5; i++)
            push(K_HOLD, c + 2 + 2 * i, 10'h3FF ^ (10'd1 << i), 4'(i));
        step();
        start = 1'b0;
        repeat (9) step();
        step();
        data_valid = 1'b0;
        chk("abort_addr5", {28'd0, addr_out}, 32'd5);
        chk("abort_rd_req", {31'd0, rd_req}, 32'd1);
        step();
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("abort");
        repeat (3) step();
        drain("abort_drain");
        rst_n = 1'b1;
        repeat (2) step();
        run_sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/deco_hold_secuenciador.md
Name: deco_hold_secuenciador

Overview:
- Parametrised successor of the register hold decoder for the RTC time/date/timer register bank.
- Drives one active-low load strobe per bank register (hold=1 keeps the value, hold=0 loads it for one cycle).
- Adds a request/acknowledge handshake to the bus read controller, a full-bank sweep mode and a timeout/error path.
- Sits between the RTC bus controller and the local hold registers that feed the display.

Parameters:
NUM_REGS, 10, number of bank registers / hold strobes (0=seg_hora ... 9=hora_timer ordering kept).
ADDR_W, 4, width of local register address.
BASE_ADDR, 0, local address mapped to hold[0].
TIMEOUT, 255, maximum cycles to wait for data_valid per register (1..255).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  single-cycle request to begin an operation.
mode  in  1  0 = single register, 1 = sweep all NUM_REGS registers.
addr_in  in  ADDR_W  target address, single mode; sampled on accepted start.
reg_rd  in  1  bus busy / read inhibit; while 1, no capture is accepted.
data_valid  in  1  bus controller: data for addr_out is present on the bus.
rd_req  out  1  read request to bus controller for addr_out.
addr_out  out  ADDR_W  address currently requested (BASE_ADDR + index).
hold  out  NUM_REGS  per-register hold; bit i low = load register i this cycle.
busy  out  1  operation in progress.
done  out  1  one-cycle pulse: operation completed successfully.
err  out  1  one-cycle pulse: out-of-range address or timeout.

Behaviour:
- All outputs registered. During reset: hold all ones, rd_req 0, busy 0, done 0, err 0, addr_out BASE_ADDR. FSM goes to IDLE; index and timeout counter are cleared.
- Reset is asynchronous and active-low. Assertion mid-operation aborts immediately and no load strobe is emitted.
- FSM states: IDLE, REQ, CAPT.
- IDLE:
  - start=1 with mode=1: index=0 → REQ.
  - start=1 with mode=0: index=addr_in-BASE_ADDR, computed ADDR_W+1 bits wide. If addr_in<BASE_ADDR or index≥NUM_REGS: err=1 next cycle, stay IDLE, no rd_req. Otherwise → REQ.
  - start while busy=1 is ignored.
- REQ:
  - rd_req=1, busy=1, addr_out=BASE_ADDR+index.
  - Timeout counter increments each cycle.
  - Accept condition: data_valid=1 AND reg_rd=0 → CAPT. data_valid while reg_rd=1 is not accepted and the counter keeps running.
  - Counter reaching TIMEOUT without accept: err pulse, rd_req drops, → IDLE, no done, hold all ones.
- CAPT (exactly one cycle):
  - hold[index]=0, all other bits 1; rd_req=0; timeout counter cleared.
  - Sweep with index<NUM_REGS-1: index+1 → REQ.
  - Otherwise → IDLE, with a done pulse in the same cycle the FSM enters IDLE.
- Latency:
  - start at cycle 0 → rd_req=1 at cycle 1.
  - Accept at cycle k → hold bit low at cycle k+1.
  - Earliest next rd_req in sweep: cycle k+2.
- Never more than one hold bit low at a time.
- hold is all ones in every state except CAPT.
- done and err are never asserted together.

Test Plan:
- Reset release, idle 20 cycles → hold=10'h3FF, rd_req=0, busy=0, done=0, err=0.
- Single mode, addr_in=4, data_valid asserted 3 cycles after rd_req:
  - rd_req high cycles 1–4, addr_out=4.
  - hold=10'h3EF for exactly 1 cycle.
  - done pulse 1 cycle later, busy back to 0.
- Sweep mode, data_valid held 1:
  - 10 load strobes, hold bit 0 through 9 low in order, each 2 cycles apart.
  - addr_out steps 0..9, single done after the bit-9 strobe, no err.
- Single mode, addr_in=12 → err pulse 1 cycle after start, no rd_req, hold stays 10'h3FF.
- Single mode addr_in=2, reg_rd=1 with data_valid=1 for TIMEOUT cycles → no hold strobe, err pulse, FSM returns to IDLE.
- Sweep in progress, reset asserted low at index 5 mid-REQ → outputs at reset values immediately. After release, a new sweep starts from index 0.
